core: RTL and testbench

CORE -- requirements
Module: core

---
 rtl/core_if.sv | 32 +++
 rtl/core.sv | 103 ++++++++++
 tb/tb_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_if.sv
// rtl/core_if.sv - control, code-RAM and display interfaces of the accumulator core
// Direction in each modport is seen from the side named by the modport.

interface core_control;
  logic running;
  logic halted;

  modport master (output running, input halted);
  modport slave  (input running, output halted);
endinterface

interface ram_bus #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  clock;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      read;

  modport master (output clock, output addr, input read);
  modport slave  (input clock, input addr, output read);
endinterface

interface display #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] value;
  logic             valid;

  modport master (output value, output valid);
  modport slave  (input value, input valid);
endinterface

// File: rtl/core.sv
// rtl/core.sv - two-cycle fetch/execute accumulator core with immediate-only ISA
// The code RAM is registered, so the word addressed during FETCH is decoded in EXEC.

module core #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic          clock,
  input  logic          reset,
  core_control.slave    ctrl,
  ram_bus.master        code_ram,
  display.master        disp
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_SUBI = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_LDHI = 4'hF;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0]      sum, sum_nxt;
  logic                  halted, halted_nxt;
  logic [WIDTH-1:0]      value, value_nxt;
  logic                  valid, valid_nxt;

  logic [3:0]            op;
  logic [11:0]           imm;

  assign op  = code_ram.read[15:12];
  assign imm = code_ram.read[11:0];

  assign code_ram.clock = clock;
  assign code_ram.addr  = pc;
  assign ctrl.halted    = halted;
  assign disp.value     = value;
  assign disp.valid     = valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      sum    <= '0;
      halted <= 1'b0;
      value  <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      sum    <= sum_nxt;
      halted <= halted_nxt;
      value  <= value_nxt;
      valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    sum_nxt    = sum;
    halted_nxt = halted;
    value_nxt  = value;
    valid_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl.running && !halted) state_nxt = FETCH;
      end
      FETCH: begin
        // Once fetched, the instruction always executes even if running drops.
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = ctrl.running ? FETCH : IDLE;
        pc_nxt    = pc + ADDR_WIDTH'(1);
        case (op)
          OP_ADDI: sum_nxt = sum + WIDTH'(imm);
          OP_SUBI: sum_nxt = sum - WIDTH'(imm);
          OP_LDI:  sum_nxt = WIDTH'(imm);
          OP_JMP:  pc_nxt  = ADDR_WIDTH'(imm);
          OP_JZ:   if (sum == '0) pc_nxt = ADDR_WIDTH'(imm);
          OP_OUT: begin
            value_nxt = sum;
            valid_nxt = 1'b1;
          end
          OP_HALT: begin
            halted_nxt = 1'b1;
            state_nxt  = IDLE;
          end
          OP_LDHI: sum_nxt[15:8] = imm[7:0];
          default: ;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - scoreboard bench for core against an instruction-level reference model
// The model executes whole instructions; the core's two-cycle timing is only used to count them.

module tb_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_control ctrl ();
  ram_bus      code ();
  display      disp ();

  core c0 (
    .clock    (clk),
    .reset    (rst),
    .ctrl     (ctrl),
    .code_ram (code),
    .disp     (disp)
  );

  logic [15:0] mem [4096];
  always @(posedge clk) code.read <= mem[code.addr];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_sum;
  logic [15:0] m_last;
  logic [11:0] m_pc;
  logic        m_halted;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sum    = 16'h0;
    m_pc     = 12'h0;
    m_halted = 1'b0;
    m_last   = 16'h0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [15:0] w;
    int          op;
    int          imm;
    bit          jumped;
    if (m_halted) return;
    w      = mem[m_pc];
    op     = int'(w) / 4096;
    imm    = int'(w) % 4096;
    jumped = 1'b0;
    case (op)
      0:  m_sum = 16'((int'(m_sum) + imm) % 65536);
      1:  m_sum = 16'((int'(m_sum) - imm + 65536) % 65536);
      2:  m_sum = 16'(imm);
      3:  begin m_pc = 12'(imm); jumped = 1'b1; end
      4:  if (m_sum == 16'h0) begin m_pc = 12'(imm); jumped = 1'b1; end
      5:  begin m_last = m_sum; exp_q.push_back(m_sum); end
      14: m_halted = 1'b1;
      15: m_sum = 16'((imm % 256) * 256 + int'(m_sum) % 256);
      default: ;
    endcase
    if (!jumped) m_pc = 12'((int'(m_pc) + 1) % 4096);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && disp.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL disp_unexpected: got value %h with no OUT expected at %0t", disp.value, $time);
      end else begin
        check("disp_value", 32'(disp.value), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic fill_nop();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h6000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    ctrl.running = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_sum"},    32'(c0.sum),      32'(m_sum));
    check({tag, "_pc"},     32'(code.addr),   32'(m_pc));
    check({tag, "_halted"}, 32'(ctrl.halted), 32'(m_halted));
    check({tag, "_disp"},   32'(disp.value),  32'(m_last));
    check({tag, "_outs"},   32'(exp_q.size()), 32'd0);
  endtask

  // From IDLE, running high for 2k or 2k-1 rising edges executes exactly k instructions.
  task automatic run_chunk(input int k, input bit late_drop, input int gap, input string tag);
    logic [11:0] pc_hold;
    logic [15:0] sum_hold;
    for (int i = 0; i < k; i++) model_step();
    ctrl.running = 1'b1;
    repeat (late_drop ? 2 * k - 1 : 2 * k) @(negedge clk);
    ctrl.running = 1'b0;
    repeat (2) @(negedge clk);
    pc_hold  = code.addr;
    sum_hold = c0.sum;
    repeat (gap) @(negedge clk);
    check({tag, "_pause_pc"},  32'(code.addr), 32'(pc_hold));
    check({tag, "_pause_sum"}, 32'(c0.sum),    32'(sum_hold));
    check_model(tag);
  endtask

  initial begin
    rst          = 1'b1;
    ctrl.running = 1'b0;
    fill_nop();
    do_reset();
    check("reset_sum",    32'(c0.sum),      32'h0);
    check("reset_pc",     32'(code.addr),   32'h0);
    check("reset_halted", 32'(ctrl.halted), 32'h0);
    check("reset_value",  32'(disp.value),  32'h0);
    check("reset_valid",  32'(disp.valid),  32'h0);

    // LDHI then ADDI with running high for five cycles, starting in reset.
    fill_nop();
    mem[0] = 16'hFF00;
    mem[1] = 16'h0F0F;
    @(negedge clk);
    rst          = 1'b1;
    ctrl.running = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    ctrl.running = 1'b0;
    repeat (4) @(negedge clk);
    check("ldhi_sum", 32'(c0.sum),    32'h0F0F);
    check("ldhi_pc",  32'(code.addr), 32'h2);

    // LDI, SUBI to -1, OUT, HALT; halted core ignores running.
    fill_nop();
    do_reset();
    mem[0] = 16'h2005;
    mem[1] = 16'h1006;
    mem[2] = 16'h5000;
    mem[3] = 16'hE000;
    run_chunk(6, 1'b0, 3, "halt");
    run_chunk(3, 1'b1, 3, "halt_frozen");

    // JZ loop back to address 0.
    fill_nop();
    do_reset();
    mem[0] = 16'h2001;
    mem[1] = 16'h1001;
    mem[2] = 16'h4000;
    for (int i = 0; i < 6; i++)
      run_chunk($urandom_range(1, 7), 1'($urandom_range(0, 1)), $urandom_range(1, 4), "jz_loop");

    // pc wraps from the top of code space to 0.
    fill_nop();
    do_reset();
    mem[0]     = 16'h4FFF;
    mem[12'hFFF] = 16'h0003;
    mem[1]     = 16'hE000;
    run_chunk(5, 1'b0, 2, "wrap");

    // Running drops during the FETCH of the second instruction, paused for six cycles.
    fill_nop();
    do_reset();
    mem[0] = 16'h0011;
    mem[1] = 16'h0022;
    mem[2] = 16'h0044;
    mem[3] = 16'h5000;
    run_chunk(2, 1'b1, 6, "pause");
    run_chunk(2, 1'b0, 2, "resume");

    // Reset during EXEC of 0x0F0F discards it.
    fill_nop();
    do_reset();
    mem[0] = 16'h2100;
    mem[1] = 16'h0F0F;
    ctrl.running = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_sum", 32'(c0.sum), 32'h0100);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    ctrl.running = 1'b0;
    model_reset();
    check("exec_reset_sum",   32'(c0.sum),     32'h0);
    check("exec_reset_pc",    32'(code.addr),  32'h0);
    check("exec_reset_valid", 32'(disp.valid), 32'h0);
    run_chunk(1, 1'b0, 2, "after_reset");

    // Random programs over the whole code space, run in random chunks.
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 4096; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hE && $urandom_range(0, 3) != 0) op = 4'h5;
        mem[i] = {op, 12'($urandom_range(0, 4095))};
      end
      do_reset();
      for (int c = 0; c < 6; c++)
        run_chunk($urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(1, 5), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
